// File: rtl/mem_io_responder.sv
// +--------------------------------------------------------------------------+
// | mem_io_responder: bus-side RAM, output-port queue and input capture.     |
// | Define OUT_FIFO_EN for the OUT_DEPTH FIFO, else a single holding reg.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_io_responder #(
  parameter int ADDR_W    = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        addr_bus,
  input  logic              c_ri,
  input  logic              c_ro,
  input  logic              mem_clk,
  input  logic              mem_io,
  inout  wire  [7:0]        bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_DRIVE = 2'd1,
    S_IO_WAIT  = 2'd2,
    S_IO_DRIVE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        rd_q, rd_d;
  logic              err_q, err_d;
  logic [7:0]        mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] w_addr;
  logic              w_conflict, w_wr, w_rd;
  logic              w_ram_we, w_push, w_io_take;
  logic              w_pop, w_ovf, w_drive;

  assign w_addr     = addr_bus[ADDR_W-1:0];
  assign w_conflict = mem_clk & c_ri & c_ro;
  assign w_wr       = mem_clk & c_ri & ~c_ro;
  assign w_rd       = mem_clk & c_ro & ~c_ri;
  // A loader write on the same edge wins; the CPU write is dropped.
  assign w_ram_we   = w_wr & ~mem_io & ~load_en;
  assign w_push     = w_wr &  mem_io & ~load_en;
  assign w_io_take  = w_rd &  mem_io & in_valid;

  assign in_ready = w_io_take & reset;
  assign err      = err_q;

  // Release is combinational on c_ro so the CPU never fights the bus.
  assign w_drive = ((state_q == S_RD_DRIVE) || (state_q == S_IO_DRIVE)) && c_ro;
  assign bus     = w_drive ? rd_q : 8'bz;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    err_d   = err_q | w_conflict | (load_en & w_wr) | w_ovf;
    if (w_rd) begin
      if (!mem_io) begin
        rd_d    = mem_q[w_addr];
        state_d = S_RD_DRIVE;
      end else if (in_valid) begin
        rd_d    = in_data;
        state_d = S_IO_DRIVE;
      end else begin
        state_d = S_IO_WAIT;
      end
    end else if ((state_q != S_IDLE) && !c_ro) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end else if (w_ram_we) begin
      mem_q[w_addr] <= bus;
    end
  end

`ifdef OUT_FIFO_EN
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_q [OUT_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          w_full, w_push_ok;

  assign w_full    = (count_q == CW'(OUT_DEPTH));
  assign w_pop     = out_valid & out_ready;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf     = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(w_push_ok) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) fifo_q[wr_ptr_q] <= bus;
  end

  assign out_data  = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
`else
  // Single holding register; OUT_DEPTH has no effect in this build.
  if (OUT_DEPTH > 0) begin : g_hold
    logic [7:0] hold_q;
    logic       full_q;

    assign w_pop = full_q & out_ready;
    assign w_ovf = w_push & full_q & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_q <= '0;
        full_q <= 1'b0;
      end else if (w_push && !w_ovf) begin
        hold_q <= bus;
        full_q <= 1'b1;
      end else if (w_pop) begin
        full_q <= 1'b0;
      end
    end

    assign out_data  = hold_q;
    assign out_valid = full_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// +--------------------------------------------------------------------------+
// | tb_mem_io_responder: scoreboard bench for mem_io_responder (OUT_FIFO_EN). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_io_responder;
  localparam int ADDR_W    = 8;
  localparam int OUT_DEPTH = 4;
`ifdef OUT_FIFO_EN
  localparam int CAP = OUT_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        addr_bus;
  logic              c_ri, c_ro, mem_clk, mem_io;
  wire  [7:0]        bus;
  logic              drv_en;
  logic [7:0]        drv_val;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic [7:0]        out_data;
  logic              out_valid;
  wire               out_ready;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              err;

  logic              rand_mode, manual_rdy, rnd_rdy;
  logic              rd_phase, started;

  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_inr = 0;

  logic [7:0]        mem_m [2**ADDR_W];
  logic [7:0]        m_q[$];
  logic [7:0]        rd_exp[$];
  logic              err_exp;

  assign bus       = drv_en ? drv_val : 8'bz;
  assign out_ready = rand_mode ? rnd_rdy : manual_rdy;

  mem_io_responder #(.ADDR_W(ADDR_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .c_ri(c_ri), .c_ro(c_ro),
    .mem_clk(mem_clk), .mem_io(mem_io), .bus(bus), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .err(err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Undriven bus reads as Z in 4-state tools and as 0 in 2-state ones.
  function automatic logic released();
    return !((|bus) === 1'b1);
  endfunction

  // Reference model: RAM image, output queue of bounded capacity, sticky error.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      rd_exp.delete();
      err_exp <= 1'b0;
    end else begin
      if (mem_clk && c_ri && c_ro) err_exp <= 1'b1;
      if (mem_clk && c_ro && !c_ri) begin
        if (!mem_io)       rd_exp.push_back(mem_m[addr_bus]);
        else if (in_valid) rd_exp.push_back(in_data);
      end
      if ((m_q.size() != 0) && out_ready) void'(m_q.pop_front());
      if (load_en) begin
        mem_m[load_addr] <= load_data;
        if (mem_clk && c_ri && !c_ro) err_exp <= 1'b1;
      end else if (mem_clk && c_ri && !c_ro) begin
        if (!mem_io)                mem_m[addr_bus] <= drv_val;
        else if (m_q.size() >= CAP) err_exp <= 1'b1;
        else                        m_q.push_back(drv_val);
      end
    end
  end

  // Monitor: compares every visible output against the model each cycle.
  always @(negedge clk) begin
    if (started && reset) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) check("out_data", {24'd0, out_data}, {24'd0, m_q[0]});
      check("err", {31'd0, err}, {31'd0, err_exp});
      check("in_ready", {31'd0, in_ready},
            {31'd0, (mem_clk && c_ro && !c_ri && mem_io && in_valid)});
      if (in_ready) n_inr++;
      if (rd_phase) begin
        if (rd_exp.size() == 0) check("rd_expected_present", 0, 1);
        else                    check("rd_data", {24'd0, bus}, {24'd0, rd_exp.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_ri = 1'b0; c_ro = 1'b0; mem_clk = 1'b0; drv_en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d, input logic io);
    addr_bus = a; drv_val = d; drv_en = 1'b1; c_ri = 1'b1; c_ro = 1'b0;
    mem_io = io; mem_clk = 1'b1;
    step();
    idle();
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic io, input int waits, input logic [7:0] d);
    addr_bus = a; mem_io = io; c_ri = 1'b0; c_ro = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < waits; k++) begin
      mem_clk = 1'b1;
      #1 check("bus_z_wait_edge", {31'd0, released()}, 1);
      step();
      mem_clk = 1'b0;
      #1 check("bus_z_waiting", {31'd0, released()}, 1);
      step();
    end
    mem_clk = 1'b1; in_data = d; in_valid = io;
    #1 check("bus_z_access_edge", {31'd0, released()}, 1);
    step();
    mem_clk = 1'b0; in_valid = 1'b0; rd_phase = 1'b1;
    step();
    rd_phase = 1'b0; c_ro = 1'b0;
    #1 check("bus_z_after_ro", {31'd0, released()}, 1);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_bus_z", {31'd0, released()}, 1);
    check("rst_err", {31'd0, err}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    int inr0;
    reset = 1'b0; started = 1'b0; rd_phase = 1'b0;
    rand_mode = 1'b0; manual_rdy = 1'b0;
    addr_bus = '0; mem_io = 1'b0; drv_val = '0; in_data = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    idle();
    repeat (2) step();
    check("init_bus_z", {31'd0, released()}, 1);
    check("init_out_valid", {31'd0, out_valid}, 0);
    check("init_in_ready", {31'd0, in_ready}, 0);
    check("init_err", {31'd0, err}, 0);
    reset = 1'b1;
    started = 1'b1;
    step();

    for (int a = 0; a < 2**ADDR_W; a++) begin
      load_en = 1'b1; load_addr = ADDR_W'(a);
      load_data = (a == 'h10) ? 8'hA5 : (a == 'h30) ? 8'h11 : 8'($urandom_range(1, 255));
      step();
    end
    load_en = 1'b0;

    cpu_rd(8'h10, 1'b0, 0, 8'h00);
    cpu_wr(8'h20, 8'h3C, 1'b0);
    cpu_rd(8'h20, 1'b0, 0, 8'h00);
    cpu_rd(8'h21, 1'b0, 0, 8'h00);
    cpu_rd(8'h1F, 1'b0, 0, 8'h00);

    inr0 = n_inr;
    cpu_rd(8'h80, 1'b1, 3, 8'h7E);
    check("in_ready_pulses", n_inr - inr0, 1);

    manual_rdy = 1'b0;
    for (int i = 1; i <= CAP + 1; i++) cpu_wr(8'h00, 8'(i), 1'b1);
    check("ovf_err", {31'd0, err}, 1);
    check("ovf_out_valid", {31'd0, out_valid}, 1);
    check("ovf_head", {24'd0, out_data}, 8'h01);
    manual_rdy = 1'b1;
    repeat (CAP + 2) step();
    check("drained", {31'd0, out_valid}, 0);
    manual_rdy = 1'b0;

    do_reset();
    addr_bus = 8'h30; drv_val = 8'h55; drv_en = 1'b1;
    c_ri = 1'b1; c_ro = 1'b1; mem_io = 1'b0; mem_clk = 1'b1;
    step();
    drv_en = 1'b0; mem_clk = 1'b0;
    #1 check("conflict_bus_z", {31'd0, released()}, 1);
    idle();
    check("conflict_err", {31'd0, err}, 1);
    cpu_rd(8'h30, 1'b0, 0, 8'h00);

    addr_bus = 8'h40; mem_io = 1'b0; c_ro = 1'b1; mem_clk = 1'b1;
    step();
    mem_clk = 1'b0;
    #1 check("drive_before_reset", {31'd0, released()}, 0);
    reset = 1'b0;
    #1 check("async_rst_bus_z", {31'd0, released()}, 1);
    check("async_rst_err", {31'd0, err}, 0);
    step();
    reset = 1'b1; c_ro = 1'b0;
    step();
    cpu_rd(8'h40, 1'b0, 0, 8'h00);
    cpu_rd(8'h10, 1'b0, 0, 8'h00);

    manual_rdy = 1'b0;
    for (int i = 0; i < CAP; i++) cpu_wr(8'h01, 8'(8'hB0 + i), 1'b1);
    manual_rdy = 1'b1;
    cpu_wr(8'h01, 8'hC7, 1'b1);
    manual_rdy = 1'b0;
    check("push_pop_full_err", {31'd0, err}, 0);
    check("push_pop_full_valid", {31'd0, out_valid}, 1);
    manual_rdy = 1'b1;
    repeat (CAP + 2) step();
    manual_rdy = 1'b0;

    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       cpu_wr(8'($urandom), 8'($urandom_range(1, 255)), 1'b0);
        1:       cpu_rd(8'($urandom), 1'b0, 0, 8'h00);
        2:       cpu_wr(8'($urandom), 8'($urandom_range(1, 255)), 1'b1);
        default: cpu_rd(8'($urandom), 1'b1, int'($urandom_range(0, 2)), 8'($urandom_range(1, 255)));
      endcase
    end
    rand_mode = 1'b0; manual_rdy = 1'b1;
    repeat (CAP + 2) step();
    check("final_drain", {31'd0, out_valid}, 0);
    check("rd_queue_empty", rd_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
